// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - I/D cache line-request arbiter onto a single memory port (option: MEM_ARBITER_RR_EN)
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req_valid,
  input  logic              i_req_rw,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [LINE_W-1:0] i_req_data,
  output logic              i_req_ready,
  output logic              i_resp_valid,
  output logic [LINE_W-1:0] i_resp_data,
  input  logic              d_req_valid,
  input  logic              d_req_rw,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [LINE_W-1:0] d_req_data,
  output logic              d_req_ready,
  output logic              d_resp_valid,
  output logic [LINE_W-1:0] d_resp_data,
  output logic              mem_req_valid,
  output logic              mem_req_rw,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [LINE_W-1:0] mem_req_data,
  input  logic              mem_req_ready,
  input  logic              mem_resp_valid,
  input  logic [LINE_W-1:0] mem_resp_data,
  output logic              busy,
  output logic              grant_d
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              state_q, state_d;
  logic                rw_q, rw_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   data_q, data_d;
  logic                gnt_q, gnt_d;
  logic [LINE_W-1:0]   i_rdata_q, i_rdata_d;
  logic [LINE_W-1:0]   d_rdata_q, d_rdata_d;
  logic                prio_d;
  logic                pick_d;

  // Tie-break: the grant register doubles as the round-robin pointer
  // (reset value 0 = "I granted last", so D wins the first tie).
`ifdef MEM_ARBITER_RR_EN
  assign prio_d = ~gnt_q;
`else
  assign prio_d = 1'b1;
`endif

  assign pick_d = d_req_valid & (~i_req_valid | prio_d);

  // Next-state, accept pulses, buffer latching and response capture
  always_comb begin
    state_d      = state_q;
    rw_d         = rw_q;
    addr_d       = addr_q;
    data_d       = data_q;
    gnt_d        = gnt_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    i_req_ready  = 1'b0;
    d_req_ready  = 1'b0;
    i_resp_valid = 1'b0;
    d_resp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_req_valid || d_req_valid) begin
          gnt_d       = pick_d;
          d_req_ready = pick_d;
          i_req_ready = ~pick_d;
          rw_d        = pick_d ? d_req_rw   : i_req_rw;
          addr_d      = pick_d ? d_req_addr : i_req_addr;
          data_d      = pick_d ? d_req_data : i_req_data;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (mem_resp_valid) begin
          if (gnt_q) d_rdata_d = mem_resp_data;
          else       i_rdata_d = mem_resp_data;
          state_d = RESP;
        end
      end
      RESP: begin
        d_resp_valid = gnt_q;
        i_resp_valid = ~gnt_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight transaction
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      gnt_q     <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      gnt_q     <= gnt_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign mem_req_valid = (state_q == ISSUE);
  assign mem_req_rw    = rw_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_data  = data_q;
  assign i_resp_data   = i_rdata_q;
  assign d_resp_data   = d_rdata_q;
  assign busy          = (state_q != IDLE);
  assign grant_d       = gnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         i_req_valid = 1'b0, i_req_rw = 1'b0;
  logic [31:0]  i_req_addr = '0;
  logic [127:0] i_req_data = '0;
  logic         i_req_ready, i_resp_valid;
  logic [127:0] i_resp_data;
  logic         d_req_valid = 1'b0, d_req_rw = 1'b0;
  logic [31:0]  d_req_addr = '0;
  logic [127:0] d_req_data = '0;
  logic         d_req_ready, d_resp_valid;
  logic [127:0] d_resp_data;
  logic         mem_req_valid, mem_req_rw;
  logic [31:0]  mem_req_addr;
  logic [127:0] mem_req_data;
  logic         mem_req_ready = 1'b0, mem_resp_valid = 1'b0;
  logic [127:0] mem_resp_data = '0;
  logic         busy, grant_d;

  int passed = 0;
  int total  = 0;

  mem_arbiter #(.ADDR_W(32), .LINE_W(128)) dut (
    .clk(clk), .reset(reset),
    .i_req_valid(i_req_valid), .i_req_rw(i_req_rw), .i_req_addr(i_req_addr),
    .i_req_data(i_req_data), .i_req_ready(i_req_ready), .i_resp_valid(i_resp_valid),
    .i_resp_data(i_resp_data),
    .d_req_valid(d_req_valid), .d_req_rw(d_req_rw), .d_req_addr(d_req_addr),
    .d_req_data(d_req_data), .d_req_ready(d_req_ready), .d_resp_valid(d_resp_valid),
    .d_resp_data(d_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .busy(busy), .grant_d(grant_d)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset;
    #1;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else passed++;
    total++; if (grant_d !== 1'b0) $display("FAIL reset_grant: got %0b want 0", grant_d); else passed++;
    total++; if (mem_req_valid !== 1'b0) $display("FAIL reset_mem_valid: got %0b want 0", mem_req_valid); else passed++;
    total++; if (mem_req_addr !== 32'h0) $display("FAIL reset_mem_addr: got %0h want 0", mem_req_addr); else passed++;
    total++; if (i_resp_data !== 128'h0 || d_resp_data !== 128'h0)
      $display("FAIL reset_resp_data: got %0h/%0h want 0/0", i_resp_data, d_resp_data); else passed++;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single_i_read;
    logic [127:0] rd;
    rd = 128'hDEADBEEF_00000001_00000002_00000003;
    i_req_valid = 1'b1; i_req_rw = 1'b0; i_req_addr = 32'h100;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    #1;
    total++; if (i_req_ready !== 1'b1 || d_req_ready !== 1'b0)
      $display("FAIL iread_accept: got i=%0b d=%0b want i=1 d=0", i_req_ready, d_req_ready); else passed++;
    tick();
    i_req_valid = 1'b0; mem_req_ready = 1'b1;
    #1;
    total++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h100 || mem_req_rw !== 1'b0)
      $display("FAIL iread_issue: got v=%0b a=%0h rw=%0b want v=1 a=100 rw=0", mem_req_valid, mem_req_addr, mem_req_rw); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL iread_busy: got %0b want 1", busy); else passed++;
    tick();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = rd;
    #1;
    total++; if (i_resp_valid !== 1'b0 || mem_req_valid !== 1'b0)
      $display("FAIL iread_wait: got resp=%0b memv=%0b want 0/0", i_resp_valid, mem_req_valid); else passed++;
    tick();
    mem_resp_valid = 1'b0;
    #1;
    total++; if (i_resp_valid !== 1'b1 || i_resp_data !== rd)
      $display("FAIL iread_resp: got v=%0b d=%0h want v=1 d=%0h", i_resp_valid, i_resp_data, rd); else passed++;
    total++; if (d_resp_valid !== 1'b0) $display("FAIL iread_no_dresp: got %0b want 0", d_resp_valid); else passed++;
    tick();
    #1;
    total++; if (i_resp_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL iread_done: got resp=%0b busy=%0b want 0/0", i_resp_valid, busy); else passed++;
  endtask

  task automatic test_d_write_delay;
    logic [127:0] wd;
    int dpulse, ipulse;
    wd = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    dpulse = 0; ipulse = 0;
    d_req_valid = 1'b1; d_req_rw = 1'b1; d_req_addr = 32'h2000; d_req_data = wd;
    #1;
    total++; if (d_req_ready !== 1'b1) $display("FAIL dwr_accept: got %0b want 1", d_req_ready); else passed++;
    tick();
    d_req_valid = 1'b0; d_req_data = '0; d_req_addr = '0;
    for (int c = 0; c < 4; c++) begin
      mem_req_ready = (c == 3);
      #1;
      total++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h2000 || mem_req_data !== wd || mem_req_rw !== 1'b1)
        $display("FAIL dwr_issue_hold%0d: got v=%0b a=%0h rw=%0b want v=1 a=2000 rw=1", c, mem_req_valid, mem_req_addr, mem_req_rw);
      else passed++;
      tick();
    end
    mem_req_ready = 1'b0;
    #1;
    total++; if (mem_req_valid !== 1'b0) $display("FAIL dwr_wait_memv: got %0b want 0", mem_req_valid); else passed++;
    if (d_resp_valid) dpulse++;
    tick();
    mem_resp_valid = 1'b1; mem_resp_data = 128'h55;
    #1;
    if (d_resp_valid) dpulse++;
    tick();
    mem_resp_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (d_resp_valid) dpulse++;
      if (i_resp_valid) ipulse++;
      tick();
    end
    total++; if (dpulse != 1) $display("FAIL dwr_resp_count: got %0d want 1", dpulse); else passed++;
    total++; if (ipulse != 0) $display("FAIL dwr_no_iresp: got %0d want 0", ipulse); else passed++;
  endtask

  task automatic test_spurious;
    mem_resp_valid = 1'b1; mem_resp_data = 128'hBAD;
    #1;
    tick();
    #1;
    total++; if (busy !== 1'b0 || i_resp_valid !== 1'b0 || d_resp_valid !== 1'b0)
      $display("FAIL spur_idle: got busy=%0b i=%0b d=%0b want 0/0/0", busy, i_resp_valid, d_resp_valid); else passed++;
    i_req_valid = 1'b1; i_req_rw = 1'b0; i_req_addr = 32'h40;
    #1;
    tick();
    i_req_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      tick();
      #1;
      total++; if (mem_req_valid !== 1'b1 || i_resp_valid !== 1'b0 || d_resp_valid !== 1'b0)
        $display("FAIL spur_issue%0d: got memv=%0b i=%0b d=%0b want 1/0/0", c, mem_req_valid, i_resp_valid, d_resp_valid);
      else passed++;
    end
    mem_resp_valid = 1'b0; mem_req_ready = 1'b1;
    #1;
    tick();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 128'h77;
    #1;
    tick();
    mem_resp_valid = 1'b0;
    #1;
    total++; if (i_resp_valid !== 1'b1 || i_resp_data !== 128'h77)
      $display("FAIL spur_final_resp: got v=%0b d=%0h want 1/77", i_resp_valid, i_resp_data); else passed++;
    tick();
  endtask

  task automatic test_contention;
    logic exp_d, got;
    int seen;
    reset = 1'b0;
    #1;
    tick();
    reset = 1'b1;
    i_req_valid = 1'b1; d_req_valid = 1'b1; i_req_rw = 1'b0; d_req_rw = 1'b0;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_resp_data = 128'h9;
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARBITER_RR_EN
      exp_d = ((k % 2) == 0);
`else
      exp_d = 1'b1;
`endif
      seen = 0; got = 1'b0;
      for (int c = 0; c < 8 && seen == 0; c++) begin
        #1;
        if (i_req_ready || d_req_ready) begin
          seen = 1;
          got = d_req_ready;
        end
        tick();
      end
      total++; if (seen == 0) $display("FAIL cont_timeout%0d: got no accept want accept", k);
      else if (got !== exp_d) $display("FAIL cont_ready%0d: got d_ready=%0b want %0b", k, got, exp_d);
      else passed++;
      #1;
      total++; if (grant_d !== exp_d) $display("FAIL cont_grant%0d: got %0b want %0b", k, grant_d, exp_d); else passed++;
    end
    i_req_valid = 1'b0; d_req_valid = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_wait;
    int dpulse;
    dpulse = 0;
    d_req_valid = 1'b1; d_req_rw = 1'b0; d_req_addr = 32'h3000;
    #1;
    tick();
    d_req_valid = 1'b0; mem_req_ready = 1'b1;
    #1;
    tick();
    mem_req_ready = 1'b0;
    #1;
    total++; if (busy !== 1'b1 || mem_req_addr !== 32'h3000)
      $display("FAIL rmw_inwait: got busy=%0b a=%0h want 1/3000", busy, mem_req_addr); else passed++;
    tick();
    reset = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || mem_req_valid !== 1'b0 || mem_req_addr !== 32'h0 || mem_req_rw !== 1'b0 || mem_req_data !== 128'h0)
      $display("FAIL rmw_cleared: got busy=%0b v=%0b a=%0h want all 0", busy, mem_req_valid, mem_req_addr); else passed++;
    total++; if (grant_d !== 1'b0) $display("FAIL rmw_grant: got %0b want 0", grant_d); else passed++;
    tick();
    reset = 1'b1; mem_resp_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (d_resp_valid) dpulse++;
      tick();
    end
    mem_resp_valid = 1'b0;
    total++; if (dpulse != 0) $display("FAIL rmw_no_dresp: got %0d want 0", dpulse); else passed++;
    test_single_i_read();
  endtask

  initial begin
    tick();
    tick();
    test_reset();
    test_single_i_read();
    tick();
    test_d_write_delay();
    test_spurious();
    test_contention();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one backing main memory between the instruction-side and data-side caches of the pipelined CPU. It accepts line-sized read/write requests from both requesters and serialises them onto a single memory port, with one transaction outstanding at a time. It returns each response only to the requester that issued it. The block sits between the two cache miss/writeback engines and the memory model, and it is what lets the I-cache and the `Cache` data cache coexist over one memory.

## Interface
Parameters:
- ADDR_W, 32, byte address width of requests and memory port
- LINE_W, 128, cache-line data width carried per transaction

Ports:
- clk  input  1  single clock, all state on rising edge
- reset  input  1  asynchronous, active-low; asserted (0) clears all state immediately
- i_req_valid / d_req_valid  input  1  requester (I / D) has a request pending; held until accepted
- i_req_rw / d_req_rw  input  1  0 = line read, 1 = line write
- i_req_addr / d_req_addr  input  ADDR_W  line address
- i_req_data / d_req_data  input  LINE_W  write data, ignored on reads
- i_req_ready / d_req_ready  output  1  one-cycle accept pulse
- i_resp_valid / d_resp_valid  output  1  one-cycle completion pulse
- i_resp_data / d_resp_data  output  LINE_W  read line, held until next response to the same side
- mem_req_valid  output  1  request to memory
- mem_req_rw  output  1  latched rw
- mem_req_addr  output  ADDR_W  latched addr
- mem_req_data  output  LINE_W  latched write data
- mem_req_ready  input  1  memory accepts the request this cycle
- mem_resp_valid  input  1  memory completes the transaction (read data or write ack)
- mem_resp_data  input  LINE_W  read line
- busy  output  1  state != IDLE
- grant_d  output  1  current or most recent grant: 1 = D side, 0 = I side

## Operation
- FSM states are IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If either req_valid is high, choose a winner per the arbitration policy (see Configuration).
  - Latch the winner's rw/addr/data into an internal buffer.
  - Pulse the winner's req_ready in the same cycle (combinational from state and valids).
  - Set grant_d, then go to ISSUE. The loser's request stays pending, with no ready pulse.
- ISSUE:
  - mem_req_valid = 1, driven from the latched fields.
  - On mem_req_ready go to WAIT; otherwise hold with the fields stable.
- WAIT:
  - On mem_resp_valid, latch mem_resp_data into the grantee's resp_data register and go to RESP.
  - Writes also wait for mem_resp_valid as the acknowledge.
- RESP:
  - Pulse the grantee's resp_valid for exactly one cycle.
  - Return to IDLE, where a new arbitration happens in that same IDLE cycle.
- Ignored inputs and outputs:
  - mem_resp_valid outside WAIT is ignored.
  - req_valid in any state other than IDLE is ignored (no ready pulse).
  - On a write, resp_data is still loaded from mem_resp_data; its value is don't-care to the requester.
- Reset (reset = 0, any state, including mid-transaction):
  - State returns to IDLE; the in-flight transaction is dropped with no resp_valid.
  - Every output is 0: req_ready, resp_valid, resp_data, mem_req_*, busy, grant_d.
  - The round-robin pointer resets so that the D side wins the first tie.

## Timing
- Accept at cycle T (IDLE, ready pulse). mem_req_valid rises at T+1.
- With mem_req_ready at T+1, WAIT begins at T+2.
- With mem_resp_valid at cycle R, resp_valid is high at R+1.
- Minimum request-to-response is 3 cycles: accept T, issue T+1, WAIT T+2 with immediate resp, RESP T+3.
- Back-to-back: the next accept occurs in the first IDLE cycle after RESP. Each transaction costs at least 4 cycles.
- mem_req_* are registered and stable throughout ISSUE.
- req_ready is combinational and never asserted while busy.

## Configuration
- MEM_ARBITER_RR_EN defined: round-robin.
  - On simultaneous requests, grant the side not granted last.
  - A single requester always wins regardless of the pointer.
  - The pointer updates on every grant.
- MEM_ARBITER_RR_EN undefined: fixed priority, with the D side always winning ties.
  - The I side can be starved by continuous D traffic; this is accepted.

## Test plan
- Reset mid-WAIT:
  - Stimulus: hold reset = 0 for 1 cycle during a D read.
  - Required: busy = 0, no d_resp_valid, all mem_req_* = 0. A new I read then completes normally.
- Single I read:
  - Stimulus: addr 0x100; memory ready immediately and responds with 0xDEADBEEF_00000001_00000002_00000003 one cycle after accept.
  - Required: i_req_ready at T, mem_req_addr = 0x100 at T+1, i_resp_valid at T+3 with that data, d_resp_valid never high.
- D write with mem_req_ready delayed 3 cycles:
  - Stimulus: addr 0x2000.
  - Required: mem_req_valid held 4 cycles with stable addr/data; exactly one d_resp_valid after mem_resp_valid.
- Simultaneous I and D read, held continuously:
  - With MEM_ARBITER_RR_EN: grants alternate D, I, D, I (grant_d = 1, 0, 1, 0).
  - Without it: D granted every time and I never granted while D is held.
- Spurious mem_resp_valid:
  - Stimulus: assert mem_resp_valid in IDLE and in ISSUE.
  - Required: no resp_valid on either side and the state is unchanged.
